// File: rtl/byte_seg_display_pkg.sv
// byte_seg_display_pkg: shared types and the 7-segment table for the byte display.
package byte_seg_display_pkg;

    typedef enum logic [1:0] {IDLE, CONV, UPDATE} state_t;

    typedef struct packed {
        logic       blank;
        logic [3:0] code;
    } digit_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low gfedcba patterns for hex codes 0..F
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    localparam digit_t DIGIT_BLANK = '{blank: 1'b1, code: 4'h0};
    localparam digit_t DIGIT_ZERO  = '{blank: 1'b0, code: 4'h0};

    function automatic digit_t mk_digit(input logic blank, input logic [3:0] code);
        return '{blank: blank, code: code};
    endfunction

endpackage

// File: rtl/byte_seg_display_seg7_decode.sv
// seg7_decode: maps a digit (code plus blank flag) to active-low segment cathodes.
module seg7_decode
    import byte_seg_display_pkg::*;
(
    input  logic [4:0] digit_i,
    output logic [6:0] seg_o
);

    digit_t d;

    assign d     = digit_t'(digit_i);
    assign seg_o = d.blank ? SEG_BLANK : SEG_TABLE[d.code];

endmodule

// File: rtl/byte_seg_display.sv
// byte_seg_display: converts a byte to decimal (double-dabble) or hex digits and
// multiplexes them onto a 4-digit common-anode 7-segment display.
module byte_seg_display
    import byte_seg_display_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] val_in,
    input  logic       val_vld,
    input  logic       hex_mode,
    output logic       busy,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] REF_LAST = CW'(REFRESH_DIV - 1);

    state_t         state_q, state_d;
    logic [7:0]     val_q, val_d;
    logic           hex_q, hex_d;
    logic [2:0]     cnt_q, cnt_d;
    logic [9:0]     bcd_q, bcd_d;
    logic [7:0]     bcd_adj;
    digit_t [3:0]   dig_q, dig_d;
    logic [CW-1:0]  ref_q, ref_d;
    logic [1:0]     scan_q, scan_d;
    logic [3:0]     hund, tens, ones;
    logic           ref_wrap;

    // Scratch: [9:8] hundreds (never exceeds 2), [7:4] tens, [3:0] ones
    assign hund     = {2'b00, bcd_q[9:8]};
    assign tens     = bcd_q[7:4];
    assign ones     = bcd_q[3:0];
    assign ref_wrap = (ref_q == REF_LAST);

    always_comb begin
        state_d = state_q;
        val_d   = val_q;
        hex_d   = hex_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        dig_d   = dig_q;
        bcd_adj[7:4] = (tens >= 4'd5) ? tens + 4'd3 : tens;
        bcd_adj[3:0] = (ones >= 4'd5) ? ones + 4'd3 : ones;
        ref_d   = ref_wrap ? '0 : ref_q + 1'b1;
        scan_d  = ref_wrap ? scan_q + 2'd1 : scan_q;
        case (state_q)
            IDLE: if (val_vld) begin
                state_d = CONV;
                val_d   = val_in;
                hex_d   = hex_mode;
                cnt_d   = '0;
                bcd_d   = '0;
            end
            CONV: begin
                bcd_d   = {bcd_q[8], bcd_adj, val_q[3'd7 - cnt_q]};
                cnt_d   = cnt_q + 3'd1;
                state_d = (cnt_q == 3'd7) ? UPDATE : CONV;
            end
            UPDATE: begin
                state_d = IDLE;
                dig_d   = hex_q
                    ? {DIGIT_BLANK, DIGIT_BLANK, mk_digit(1'b0, val_q[7:4]), mk_digit(1'b0, val_q[3:0])}
                    : {DIGIT_BLANK, mk_digit(hund == 4'd0, hund),
                       mk_digit((hund == 4'd0) && (tens == 4'd0), tens), mk_digit(1'b0, ones)};
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            val_q   <= '0;
            hex_q   <= 1'b0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            dig_q   <= {DIGIT_BLANK, DIGIT_BLANK, DIGIT_BLANK, DIGIT_ZERO};
            ref_q   <= '0;
            scan_q  <= '0;
        end else begin
            state_q <= state_d;
            val_q   <= val_d;
            hex_q   <= hex_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            dig_q   <= dig_d;
            ref_q   <= ref_d;
            scan_q  <= scan_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign an   = ~(4'b0001 << scan_q);
    assign dp   = 1'b1;

    seg7_decode u_dec (
        .digit_i (dig_q[scan_q]),
        .seg_o   (seg)
    );

endmodule

// File: tb/tb_byte_seg_display.sv
// tb_byte_seg_display: directed vectors with hand-computed digit patterns.
module tb_byte_seg_display;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] val_in = '0;
    logic       val_vld = 1'b0;
    logic       hex_mode = 1'b0;
    logic       busy;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;

    int n_vec = 0;
    int n_bad = 0;

    localparam logic [6:0] BL = 7'b1111111;

    always #5 clk = ~clk;

    byte_seg_display #(.REFRESH_DIV(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .val_in   (val_in),
        .val_vld  (val_vld),
        .hex_mode (hex_mode),
        .busy     (busy),
        .seg      (seg),
        .an       (an),
        .dp       (dp)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // One full scan period; digit patterns packed as {d3,d2,d1,d0}
    task automatic grab(output logic [27:0] d);
        d = '0;
        repeat (16) begin
            @(negedge clk);
            case (an)
                4'b1110: d[6:0]   = seg;
                4'b1101: d[13:7]  = seg;
                4'b1011: d[20:14] = seg;
                4'b0111: d[27:21] = seg;
                default: ;
            endcase
        end
    endtask

    task automatic send(input logic [7:0] v, input logic h);
        @(negedge clk);
        val_in   = v;
        hex_mode = h;
        val_vld  = 1'b1;
        @(negedge clk);
        val_vld  = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy === 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        check(tag, n, 9);
    endtask

    task automatic run(input logic [7:0] v, input logic h, input logic [27:0] exp, input string tag);
        logic [27:0] d;
        send(v, h);
        wait_idle({tag, "_lat"});
        grab(d);
        check({tag, "_dig"}, d, exp);
    endtask

    initial begin
        logic [27:0] d;
        val_in  = 8'd55;
        val_vld = 1'b1;
        repeat (3) @(negedge clk);
        rst_n   = 1'b1;
        val_vld = 1'b0;
        check("rst_an", an, 4'b1110);
        check("rst_seg", seg, 7'b1000000);
        check("rst_busy", busy, 1'b0);
        check("rst_dp", dp, 1'b1);
        repeat (3) @(negedge clk);
        check("scan_hold", an, 4'b1110);
        @(negedge clk);
        check("scan_step", an, 4'b1101);
        grab(d);
        check("rst_dig", d, {BL, BL, BL, 7'b1000000});

        run(8'd255, 1'b0, {BL, 7'b0100100, 7'b0010010, 7'b0010010}, "dec255");
        run(8'd7,   1'b0, {BL, BL, BL, 7'b1111000}, "dec7");
        run(8'd100, 1'b0, {BL, 7'b1111001, 7'b1000000, 7'b1000000}, "dec100");
        run(8'd42,  1'b0, {BL, BL, 7'b0011001, 7'b0100100}, "dec42");
        run(8'hA5,  1'b1, {BL, BL, 7'b0001000, 7'b0010010}, "hexA5");
        run(8'h00,  1'b1, {BL, BL, 7'b1000000, 7'b1000000}, "hex00");
        run(8'h3C,  1'b1, {BL, BL, 7'b0110000, 7'b1000110}, "hex3C");

        // Second strobe during conversion must be dropped
        send(8'd200, 1'b0);
        @(negedge clk);
        @(negedge clk);
        val_in  = 8'd9;
        val_vld = 1'b1;
        @(negedge clk);
        val_vld = 1'b0;
        check("drop_busy", busy, 1'b1);
        begin
            int n = 4;
            while (busy === 1'b1 && n < 30) begin
                n++;
                @(negedge clk);
            end
            check("drop_lat", n, 10);
        end
        grab(d);
        check("drop_dig", d, {BL, 7'b0100100, 7'b1000000, 7'b1000000});
        check("drop_idle", busy, 1'b0);

        // Reset in the middle of a conversion
        send(8'd123, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_busy", busy, 1'b0);
        check("mid_an", an, 4'b1110);
        check("mid_seg", seg, 7'b1000000);
        rst_n = 1'b1;
        grab(d);
        check("mid_dig", d, {BL, BL, BL, 7'b1000000});
        check("mid_idle", busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/byte_seg_display.md
BYTE_SEG_DISPLAY -- requirements
Module: byte_seg_display

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, clk cycles each digit stays enabled (minimum 2).
REQ-002 clk  in  1  rising-edge system clock.
REQ-003 rst_n  in  1  reset, synchronous and active-low.
REQ-004 val_in  in  8  random byte from the generator output register.
REQ-005 val_vld  in  1  single-cycle strobe; val_in valid this cycle.
REQ-006 hex_mode  in  1  1 = hexadecimal display, 0 = unsigned decimal; sampled with val_vld.
REQ-007 busy  out  1  conversion in progress; val_vld ignored while high.
REQ-008 seg  out  7  active-low cathodes, seg[0]=CA ... seg[6]=CG.
REQ-009 an  out  4  active-low anodes, an[0] = rightmost digit.
REQ-010 dp  out  1  decimal point, constant 1 (off).

Function
REQ-011 FSM states: IDLE, CONV, UPDATE; after reset, IDLE.
REQ-012 IDLE with val_vld=1 at edge t: latch val_in and hex_mode, clear BCD scratch, go to CONV, bit counter = 0.
REQ-013 CONV: one shift-add-3 (double-dabble) step per cycle, 8 cycles (edges t+1..t+8), then UPDATE.
REQ-014 UPDATE (edge t+9): load display digit registers, return to IDLE; new digits visible from cycle t+10.
REQ-015 busy = 1 exactly in CONV and UPDATE; latency identical in both modes.
REQ-016 val_vld asserted while busy is dropped, not queued; next accept is the first IDLE cycle.
REQ-017 Decimal: digit2 = hundreds, digit1 = tens, digit0 = ones, digit3 blank.
REQ-018 Decimal leading-zero blanking: digit2 blank if hundreds = 0; digit1 blank if hundreds = 0 and tens = 0; digit0 never blank.
REQ-019 Hex: digit1 = val[7:4], digit0 = val[3:0], digits 3 and 2 blank, no zero blanking.
REQ-020 Refresh counter counts 0..REFRESH_DIV-1; at the terminal count it wraps to 0 and scan index advances 0->1->2->3->0.
REQ-021 an = only bit [scan index] low; seg = encoding of that digit, 7'b1111111 if blank.
REQ-022 Scan continues unchanged during conversion; displayed digits change only at UPDATE.
REQ-023 Encoding 0-F (gfedcba, active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-024 All outputs registered or driven from registers through the decoder only; no combinational path from val_in to seg/an.

Reset
REQ-025 rst_n low at an edge, in any state including mid-CONV: FSM IDLE, busy 0, scratch cleared, refresh counter 0, scan index 0.
REQ-026 Reset display content: digit0 = 0, digits 3..1 blank; outputs an = 4'b1110, seg = 7'b1000000, dp = 1.
REQ-027 val_vld coincident with rst_n low is ignored.

Structure
REQ-028 Shared package holds the state enum, the 16-entry segment table, SEG_BLANK = 7'b1111111, and a 5-bit digit type (4-bit code plus blank flag).
REQ-029 One combinational sub-module seg7_decode (digit type in, seg out); conversion FSM and scan logic stay in byte_seg_display.

Verification (REFRESH_DIV = 4 on bench)
REQ-030 Reset release -> an = 1110, seg = 1000000, busy = 0, dp = 1; scan index advances every 4 cycles.
REQ-031 val_in = 255, hex_mode = 0, val_vld at t -> busy high t+1..t+9; from t+10 an 1110/1101/1011 show 5 (0010010)/5/2 (0100100), an 0111 shows 1111111.
REQ-032 val_in = 7 decimal -> digit0 = 1111000, digits 1..3 = 1111111; val_in = 100 -> digits 1, 0, 0, digit3 blank.
REQ-033 val_in = 8'hA5, hex_mode = 1 -> digit1 = 0001000, digit0 = 0010010, digits 2,3 blank; val_in = 8'h00 hex -> digit1 and digit0 both 1000000.
REQ-034 val_vld with 8'd200 at t, val_vld with 8'd9 at t+3 -> display 200 at t+10, 9 never shown, busy low at t+10.
REQ-035 rst_n low at t+4 during 8'd123 conversion -> next cycle busy = 0, an = 1110, seg = 1000000; 123 never displayed.
